// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall.
// Define ID_EX_FWD_EN for forwarding; otherwise RAW hazards stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_dest,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic [3:0]  id_alu_control,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALUControl,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_store_data,
    output logic        stall
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic        alu_src;
        logic [3:0]  alu_ctl;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;

    always_comb begin
        d           = '0;
        d.valid     = id_valid;
        d.rs        = id_rs;
        d.rt        = id_rt;
        d.dest      = id_dest;
        d.rs_data   = id_rs_data;
        d.rt_data   = id_rt_data;
        d.imm       = id_imm;
        d.alu_src   = id_alu_src;
        d.alu_ctl   = id_alu_control;
        d.reg_write = id_reg_write;
        d.mem_read  = id_mem_read;
        d.mem_write = id_mem_write;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (flush || stall) begin
            q.valid <= 1'b0;
        end else begin
            q <= d;
        end
    end

    // rt only matters when it feeds the ALU or is store data
    logic rt_used;
    logic ex_hit;
    logic load_use;

    assign rt_used = ~id_alu_src | id_mem_write;
    assign ex_hit  = (q.dest != 5'd0) &&
                     ((q.dest == id_rs) ||
                      ((q.dest == id_rt) && rt_used));

    assign load_use = id_valid & q.valid & q.mem_read & ex_hit;

    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

`ifdef ID_EX_FWD_EN
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] d_reg
    );
        if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == r)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == r)
            return memwb_result;
        else
            return d_reg;
    endfunction

    assign rs_fwd = fwd(q.rs, q.rs_data);
    assign rt_fwd = fwd(q.rt, q.rt_data);
    assign stall  = load_use;
`else
    logic mem_hit;
    logic raw_hz;
    logic unused_fwd;

    assign mem_hit = (exmem_rd != 5'd0) &&
                     ((exmem_rd == id_rs) ||
                      ((exmem_rd == id_rt) && rt_used));

    // without bypass, any in-flight producer must drain to WB first
    assign raw_hz = id_valid &
                    ((q.valid & q.reg_write & ex_hit) |
                     (exmem_reg_write & mem_hit));

    assign rs_fwd     = q.rs_data;
    assign rt_fwd     = q.rt_data;
    assign stall      = load_use | raw_hz;
    assign unused_fwd = ^{exmem_result, memwb_reg_write,
                          memwb_rd, memwb_result};
`endif

    assign A             = rs_fwd;
    assign B             = q.alu_src ? q.imm : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ALUControl    = q.alu_ctl;
    assign ex_valid      = q.valid;
    assign ex_dest       = q.dest;
    assign ex_reg_write  = q.reg_write & q.valid;
    assign ex_mem_read   = q.mem_read & q.valid;
    assign ex_mem_write  = q.mem_write & q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Expectations follow ID_EX_FWD_EN when that macro is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic [4:0]  id_dest = '0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic [31:0] id_imm = '0;
    logic        id_alu_src = 1'b0;
    logic [3:0]  id_alu_control = '0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0;
    logic        flush = 1'b0;
    logic        exmem_reg_write = 1'b0;
    logic [4:0]  exmem_rd = '0;
    logic [31:0] exmem_result = '0;
    logic        memwb_reg_write = 1'b0;
    logic [4:0]  memwb_rd = '0;
    logic [31:0] memwb_result = '0;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [4:0]  ex_dest;
    logic [31:0] ex_store_data;
    logic        stall;

    int n_chk = 0;
    int n_pass = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dest(id_dest), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_control(id_alu_control),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .A(A), .B(B), .ALUControl(ALUControl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic asrc,
                          input logic [3:0] ctl, input logic rw,
                          input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_dest = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = asrc; id_alu_control = ctl;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic set_exmem(input logic rw, input logic [4:0] rd,
                             input logic [31:0] res);
        exmem_reg_write = rw; exmem_rd = rd; exmem_result = res;
    endtask

    task automatic set_memwb(input logic rw, input logic [4:0] rd,
                             input logic [31:0] res);
        memwb_reg_write = rw; memwb_rd = rd; memwb_result = res;
    endtask

    initial begin
        // reset overrides a valid instruction at the edge
        set_id(1, 1, 2, 3, 5, 7, 0, 0, 4'b0010, 1, 0, 0);
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_A", A, 0);
        chk("rst_alu", ALUControl, 0);
        chk("rst_dest", ex_dest, 0);
        chk("rst_stall", stall, 0);

        // ADD r3,r1,r2
        reset = 1'b0;
        step();
        chk("add_A", A, 5);
        chk("add_B", B, 7);
        chk("add_alu", ALUControl, 4'b0010);
        chk("add_dest", ex_dest, 3);
        chk("add_rw", ex_reg_write, 1);
        chk("add_sd", ex_store_data, 7);

`ifdef ID_EX_FWD_EN
        // SUB r4,r3,r1 with r3 forwarded from EX/MEM
        set_id(1, 3, 1, 4, 99, 5, 0, 0, 4'b0110, 1, 0, 0);
        set_exmem(1, 3, 12);
        #1;
        chk("sub_stall", stall, 0);
        step();
        chk("sub_A", A, 12);
        chk("sub_B", B, 5);
        chk("sub_alu", ALUControl, 4'b0110);
        chk("sub_sd", ex_store_data, 5);
        set_exmem(1, 3, 1);
        set_memwb(1, 3, 2);
        #1;
        chk("prio_A", A, 1);
        set_exmem(1, 0, 1);
        set_memwb(1, 0, 2);
        #1;
        chk("r0_A", A, 99);
        set_memwb(1, 3, 2);
        #1;
        chk("memwb_A", A, 2);
`else
        // SUB r4,r3,r1 waits until ADD reaches WB
        set_id(1, 3, 1, 4, 0, 5, 0, 0, 4'b0110, 1, 0, 0);
        #1;
        chk("raw_stall_ex", stall, 1);
        step();
        chk("raw_bub_v", ex_valid, 0);
        chk("raw_bub_rw", ex_reg_write, 0);
        set_exmem(1, 3, 12);
        #1;
        chk("raw_stall_mem", stall, 1);
        step();
        chk("raw_bub2_v", ex_valid, 0);
        set_exmem(0, 0, 0);
        set_memwb(1, 3, 12);
        id_rs_data = 12;
        #1;
        chk("raw_stall_wb", stall, 0);
        step();
        chk("sub_A", A, 12);
        chk("sub_B", B, 5);
        chk("sub_alu", ALUControl, 4'b0110);
        set_exmem(1, 3, 1);
        #1;
        chk("nofwd_A", A, 12);
`endif
        set_exmem(0, 0, 0);
        set_memwb(0, 0, 0);

        // LW r5,8(r1)
        set_id(1, 1, 5, 5, 100, 0, 8, 1, 4'b0010, 1, 1, 0);
        step();
        chk("lw_A", A, 100);
        chk("lw_B", B, 8);
        chk("lw_mr", ex_mem_read, 1);

        // ADD r6,r5,r1 -> single load-use bubble
        set_id(1, 5, 1, 6, 55, 100, 0, 0, 4'b0010, 1, 0, 0);
        #1;
        chk("lu_stall", stall, 1);
        step();
        chk("lu_bub_v", ex_valid, 0);
        chk("lu_bub_rw", ex_reg_write, 0);
        chk("lu_bub_mr", ex_mem_read, 0);
        chk("lu_stall_clr", stall, 0);
        step();
        chk("lu_add_v", ex_valid, 1);
        chk("lu_add_A", A, 55);
        chk("lu_add_B", B, 100);

        // flush wins over stall
        set_id(1, 1, 8, 8, 0, 0, 4, 1, 4'b0010, 1, 1, 0);
        step();
        set_id(1, 8, 8, 9, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
        #1;
        chk("fl_stall", stall, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_v", ex_valid, 0);
        chk("fl_rw", ex_reg_write, 0);

        // reset in the middle of a load-use stall
        set_id(1, 1, 8, 8, 3, 0, 4, 1, 4'b0010, 1, 1, 0);
        step();
        set_id(1, 8, 8, 9, 0, 0, 0, 0, 4'b0010, 1, 0, 0);
        #1;
        chk("mr_stall", stall, 1);
        reset = 1'b1;
        step();
        chk("mr_v", ex_valid, 0);
        chk("mr_A", A, 0);
        chk("mr_B", B, 0);
        chk("mr_alu", ALUControl, 0);
        chk("mr_dest", ex_dest, 0);
        chk("mr_mr", ex_mem_read, 0);
        chk("mr_sd", ex_store_data, 0);
        chk("mr_stall_clr", stall, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk input 1: sole clock; all state updates on rising edge.
REQ-002 reset input 1: synchronous, active-high reset.
REQ-003 id_valid input 1; id_rs, id_rt, id_dest input 5 each: decode-stage instruction valid, source and destination register numbers.
REQ-004 id_rs_data, id_rt_data, id_imm input 32 each: register-file read data and sign-extended immediate.
REQ-005 id_alu_src input 1 (1 = B from immediate); id_alu_control input 4; id_reg_write, id_mem_read, id_mem_write input 1 each.
REQ-006 flush input 1: kill the instruction entering EX.
REQ-007 exmem_reg_write input 1, exmem_rd input 5, exmem_result input 32: EX/MEM forwarding source.
REQ-008 memwb_reg_write input 1, memwb_rd input 5, memwb_result input 32: MEM/WB forwarding source.
REQ-009 A, B output 32; ALUControl output 4: ALU operands and operation code.
REQ-010 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write output 1; ex_dest output 5; ex_store_data output 32.
REQ-011 stall output 1, combinational: decode stage holds its instruction while high.

Function
REQ-012 Register capture: each edge with no reset, flush or stall, all id_* fields are registered; ex_valid <= id_valid.
REQ-013 Latency: one cycle from id_* capture to A/B/ALUControl presentation.
REQ-014 ALUControl codes passed unchanged: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
REQ-015 Forwarded rs value = exmem_result if exmem_reg_write, exmem_rd != 0 and exmem_rd == registered rs; else memwb_result if same conditions on MEM/WB; else registered rs data.
REQ-016 Forwarded rt value: identical rule on registered rt; EX/MEM priority over MEM/WB.
REQ-017 A = forwarded rs; B = registered imm if registered alu_src, else forwarded rt; ex_store_data = forwarded rt always.
REQ-018 Register 0 never forwarded; matches on rd == 0 ignored.
REQ-019 ex_reg_write, ex_mem_read, ex_mem_write = registered values AND ex_valid; never high for a bubble.
REQ-020 Load-use hazard: stall = id_valid & ex_valid & ex_mem_read & ex_dest != 0 & (ex_dest == id_rs | (ex_dest == id_rt & (!id_alu_src | id_mem_write))).
REQ-021 On stall without flush: bubble inserted, ex_valid <= 0, other registers hold; ID re-presents the same instruction next cycle.
REQ-022 flush: ex_valid <= 0 next edge regardless of stall; flush wins over stall and capture.
REQ-023 Stall lasts exactly one cycle per load-use pair (bubble clears the match).
REQ-024 Register file is write-before-read; MEM/WB writes same cycle as ID read need no extra handling.

Reset
REQ-025 reset high at an edge: ex_valid, all control bits, ex_dest, ALUControl (0000), registered rs/rt/dest, data and imm cleared to 0; overrides flush and capture.
REQ-026 During and after reset, A/B reflect zeroed registers unless forwarding matches nonzero rd; stall = 0 while ex_valid = 0.

Configuration
REQ-027 Macro ID_EX_FWD_EN defined: forwarding per REQ-015..018.
REQ-028 ID_EX_FWD_EN undefined: no forwarding muxes; A/rt taken from registered data; stall additionally asserted when id_valid and a nonzero id source (REQ-020 rt qualification) matches ex_dest with ex_valid & ex_reg_write, or exmem_rd with exmem_reg_write.

Verification
REQ-029 ADD r3,r1,r2 with r1=5, r2=7, no forwarding -> next cycle A=5, B=7, ALUControl=0010, ex_dest=3, ex_reg_write=1.
REQ-030 SUB r4,r3,r1 after ADD writing r3, exmem_result=12 -> A=12 (forwarded), B=5, ALUControl=0110.
REQ-031 exmem_rd=memwb_rd=3, exmem_result=1, memwb_result=2, both write -> A=1; with rd=0 on both -> A=registered value.
REQ-032 LW r5 in EX, ID ADD r6,r5,r1 -> stall=1 one cycle, next ex_valid=0 with ex_reg_write=0, then ADD captured, stall=0.
REQ-033 flush=1 together with stall=1 -> next ex_valid=0; reset mid-stall -> all outputs zero, stall=0.
REQ-034 ID_EX_FWD_EN undefined, ADD r3 then ADD r4,r3,r3 -> stall for two cycles, A = r3 value from register file afterward.
